// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared constants, FSM states and polynomial type for the Kyber matrix expander
package kyber_pkg;

  localparam int Q           = 3329;
  localparam int N           = 256;
  localparam int COEF_W      = 16;
  localparam int STREAM_BITS = 5376;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XOF_REQ,
    ST_XOF_WAIT,
    ST_SAMPLE,
    ST_OUT,
    ST_DONE
  } exp_state_e;

  typedef logic [N*COEF_W-1:0] poly_t;

endpackage

// File: rtl/poly_rej_sampler.sv
// rtl/poly_rej_sampler.sv - 12-bit rejection sampler, one 3-byte group per cycle into N coefficients below Q
module poly_rej_sampler
  import kyber_pkg::*;
#(
  parameter int N           = kyber_pkg::N,
  parameter int COEF_W      = kyber_pkg::COEF_W,
  parameter int Q           = kyber_pkg::Q,
  parameter int STREAM_BITS = kyber_pkg::STREAM_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [STREAM_BITS-1:0] stream_i,
  output logic [N*COEF_W-1:0]    coef_o,
  output logic                   done_o,
  output logic                   exhaust_o
);

  localparam int GROUPS = STREAM_BITS / 24;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int GRP_W  = $clog2(GROUPS);
  localparam logic [CNT_W-1:0] N_C      = CNT_W'(N);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);
  localparam logic [11:0]      Q12      = 12'(Q);

  logic                active_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d, slot2;
  logic [GRP_W-1:0]    grp_q;
  logic [N*COEF_W-1:0] coef_q;
  logic [23:0]         grp_bits;
  logic [11:0]         d1, d2;
  logic                w1, w2, full;

  // d1 = b0 + 256*(b1 & 0xF) and d2 = (b1 >> 4) + 16*b2 are simply the two 12-bit halves
  always_comb begin
    grp_bits  = stream_i[grp_q*24 +: 24];
    d1        = grp_bits[11:0];
    d2        = grp_bits[23:12];
    w1        = (d1 < Q12) && (cnt_q < N_C);
    slot2     = cnt_q + {{(CNT_W-1){1'b0}}, w1};
    w2        = (d2 < Q12) && (slot2 < N_C);
    cnt_d     = slot2 + {{(CNT_W-1){1'b0}}, w2};
    full      = (cnt_d == N_C);
    done_o    = active_q && (full || (grp_q == GRP_LAST));
    exhaust_o = active_q && (grp_q == GRP_LAST) && !full;
  end

  assign coef_o = coef_q;

  // Clearing on start makes the zero-fill of an exhausted stream free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      grp_q    <= '0;
      coef_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      grp_q    <= '0;
      coef_q   <= '0;
    end else if (active_q) begin
      if (w1) coef_q[cnt_q*COEF_W +: COEF_W] <= {{(COEF_W-12){1'b0}}, d1};
      if (w2) coef_q[slot2*COEF_W +: COEF_W] <= {{(COEF_W-12){1'b0}}, d2};
      cnt_q <= cnt_d;
      grp_q <= grp_q + GRP_W'(1);
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/kyber_matrix_expander.sv
// rtl/kyber_matrix_expander.sv - Kyber matrix A / A^T expander; MATRIX_EXP_STORE_EN adds a readable coefficient store
module kyber_matrix_expander
  import kyber_pkg::*;
#(
  parameter int K           = 3,
  parameter int N           = kyber_pkg::N,
  parameter int COEF_W      = kyber_pkg::COEF_W,
  parameter int Q           = kyber_pkg::Q,
  parameter int STREAM_BITS = kyber_pkg::STREAM_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   transpose,
  output logic                   busy,
  output logic                   done,
  output logic                   err_exhaust,
  output logic                   xof_req,
  output logic [7:0]             xof_b0,
  output logic [7:0]             xof_b1,
  input  logic                   xof_done,
  input  logic [STREAM_BITS-1:0] xof_stream,
  output logic                   poly_valid,
  input  logic                   poly_ready,
  output logic [N*COEF_W-1:0]    poly_data,
  output logic [$clog2(K)-1:0]   poly_row,
  output logic [$clog2(K)-1:0]   poly_col,
  output logic [3:0]             poly_index
`ifdef MATRIX_EXP_STORE_EN
  ,
  input  logic [3:0]             rd_index,
  input  logic [$clog2(N)-1:0]   rd_coef,
  output logic [COEF_W-1:0]      rd_data
`endif
);

  localparam int RC_W = $clog2(K);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(K - 1);

  exp_state_e      state_q, state_d;
  logic [RC_W-1:0] row_q, row_d, col_q, col_d;
  logic            tr_q, tr_d, err_q, err_d;
  logic            smp_start, smp_done, smp_exhaust;

  poly_rej_sampler #(
    .N(N), .COEF_W(COEF_W), .Q(Q), .STREAM_BITS(STREAM_BITS)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .start_i   (smp_start),
    .stream_i  (xof_stream),
    .coef_o    (poly_data),
    .done_o    (smp_done),
    .exhaust_o (smp_exhaust)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      tr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tr_q    <= tr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    tr_d      = tr_q;
    err_d     = err_q;
    smp_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_XOF_REQ;
          row_d   = '0;
          col_d   = '0;
          tr_d    = transpose;
          err_d   = 1'b0;
        end
      end
      ST_XOF_REQ:  state_d = ST_XOF_WAIT;
      ST_XOF_WAIT: begin
        if (xof_done) begin
          smp_start = 1'b1;
          state_d   = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (smp_done) begin
          state_d = ST_OUT;
          err_d   = err_q | smp_exhaust;
        end
      end
      ST_OUT: begin
        if (poly_ready) begin
          if (col_q != RC_LAST) begin
            col_d   = col_q + RC_W'(1);
            state_d = ST_XOF_REQ;
          end else if (row_q != RC_LAST) begin
            col_d   = '0;
            row_d   = row_q + RC_W'(1);
            state_d = ST_XOF_REQ;
          end else begin
            col_d   = '0;
            row_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transposed matrix entry (r,c) is the stream normally used for (c,r)
  assign xof_b0      = tr_q ? 8'(row_q) : 8'(col_q);
  assign xof_b1      = tr_q ? 8'(col_q) : 8'(row_q);
  assign xof_req     = (state_q == ST_XOF_REQ);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done        = (state_q == ST_DONE);
  assign err_exhaust = err_q;
  assign poly_valid  = (state_q == ST_OUT);
  assign poly_row    = row_q;
  assign poly_col    = col_q;
  assign poly_index  = 4'(row_q * K + col_q);

`ifdef MATRIX_EXP_STORE_EN
  logic [N*COEF_W-1:0] store_q [K*K];
  logic [COEF_W-1:0]   rd_data_q;

  always_ff @(posedge clk) begin
    if (poly_valid && poly_ready) store_q[poly_index] <= poly_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_index < 4'(K * K)) begin
      rd_data_q <= store_q[rd_index][rd_coef*COEF_W +: COEF_W];
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_kyber_matrix_expander.sv
// tb/tb_kyber_matrix_expander.sv - vector table plus scoreboard bench for kyber_matrix_expander
module tb_kyber_matrix_expander;

  localparam int K  = 3;
  localparam int N  = 256;
  localparam int CW = 16;
  localparam int Q  = 3329;
  localparam int SB = 5376;

  logic           clk = 1'b0, rst = 1'b1, start = 1'b0, transpose = 1'b0, poly_ready = 1'b1;
  logic           busy, done, err_exhaust, xof_req, xof_done, poly_valid;
  logic [7:0]     xof_b0, xof_b1;
  logic [SB-1:0]  xof_stream;
  logic [N*CW-1:0] poly_data;
  logic [1:0]     poly_row, poly_col;
  logic [3:0]     poly_index;
`ifdef MATRIX_EXP_STORE_EN
  logic [3:0]     rd_index = '0;
  logic [7:0]     rd_coef = '0;
  logic [CW-1:0]  rd_data;
`endif

  kyber_matrix_expander #(.K(K), .N(N), .COEF_W(CW), .Q(Q), .STREAM_BITS(SB)) dut (
    .clk(clk), .rst(rst), .start(start), .transpose(transpose),
    .busy(busy), .done(done), .err_exhaust(err_exhaust),
    .xof_req(xof_req), .xof_b0(xof_b0), .xof_b1(xof_b1),
    .xof_done(xof_done), .xof_stream(xof_stream),
    .poly_valid(poly_valid), .poly_ready(poly_ready), .poly_data(poly_data),
    .poly_row(poly_row), .poly_col(poly_col), .poly_index(poly_index)
`ifdef MATRIX_EXP_STORE_EN
    , .rd_index(rd_index), .rd_coef(rd_coef), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [N*CW-1:0] data; int row; int col; } sb_t;
  typedef struct { logic [47:0] bytes; int c0; int c1; } vec_t;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, lat, t_done = 0, t_hs = 0, order = 0, exp_gap = 0, smode = 0;
  logic run_tr = 0, exp_err = 0, chk_gap = 0, pfx_en = 0, pv_prev = 0;
  logic [47:0] pfx = '0;
  logic [7:0] rb0, rb1;
  sb_t sb[$];
  logic [N*CW-1:0] exp_idx [K*K];
  logic [N*CW-1:0] cap_idx [K*K];
  logic [N*CW-1:0] exp_n [K*K];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_poly(input string name, input logic [N*CW-1:0] act, input logic [N*CW-1:0] exp);
    int bad = -1;
    n_chk++;
    for (int i = N - 1; i >= 0; i--) if (act[i*CW +: CW] !== exp[i*CW +: CW]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: coef %0d got %0d expected %0d", name, bad, act[bad*CW +: CW], exp[bad*CW +: CW]);
    end
  endtask

  // Deterministic stand-in for SHAKE128: xorshift keyed by the index bytes
  function automatic logic [SB-1:0] make_stream(input logic [7:0] b0, input logic [7:0] b1);
    logic [SB-1:0] s;
    logic [31:0] x;
    x = {8'h5a, b1, b0, 8'hc3} ^ 32'h9e3779b9;
    for (int i = 0; i < SB / 8; i++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      case (smode)
        1:       s[i*8 +: 8] = 8'hff;
        2:       s[i*8 +: 8] = 8'h00;
        default: s[i*8 +: 8] = x[7:0];
      endcase
      if (pfx_en && b0 == 8'd0 && b1 == 8'd0 && i < 6) s[i*8 +: 8] = pfx[47-8*i -: 8];
    end
    return s;
  endfunction

  function automatic void golden(input logic [SB-1:0] s, output logic [N*CW-1:0] p, output logic ex);
    int cnt, d1, d2, b0, b1, b2;
    cnt = 0;
    p = '0;
    for (int g = 0; g < SB / 24 && cnt < N; g++) begin
      b0 = int'(s[g*24 +: 8]);
      b1 = int'(s[g*24+8 +: 8]);
      b2 = int'(s[g*24+16 +: 8]);
      d1 = b0 + 256 * (b1 % 16);
      d2 = (b1 / 16) + 16 * b2;
      if (d1 < Q) begin p[cnt*CW +: CW] = CW'(d1); cnt++; end
      if (d2 < Q && cnt < N) begin p[cnt*CW +: CW] = CW'(d2); cnt++; end
    end
    ex = (cnt < N);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      xof_done <= 1'b0;
      lat      <= 0;
    end else if (xof_req) begin
      xof_done <= 1'b0;
      lat      <= 3;
      rb0      <= xof_b0;
      rb1      <= xof_b1;
    end else if (lat == 1) begin
      xof_stream <= make_stream(rb0, rb1);
      xof_done   <= 1'b1;
      lat        <= 0;
      t_done     <= cyc;
    end else if (lat > 1) begin
      lat <= lat - 1;
    end
  end

  always @(negedge clk) begin
    sb_t e;
    logic [N*CW-1:0] gp;
    logic ex;
    int r, c;
    if (!rst) begin
      if (xof_req) begin
        check("xof_req_in_range", order < K * K, 1);
        r = order / K;
        c = order % K;
        check("xof_b0", xof_b0, run_tr ? r : c);
        check("xof_b1", xof_b1, run_tr ? c : r);
        golden(make_stream(8'(run_tr ? r : c), 8'(run_tr ? c : r)), gp, ex);
        e.data = gp; e.row = r; e.col = c;
        sb.push_back(e);
        if (order < K * K) exp_idx[order] = gp;
        exp_err = exp_err | ex;
        order++;
      end
      if (poly_valid && poly_ready) begin
        t_hs = cyc;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_poly("poly_data", poly_data, e.data);
          check("poly_row", poly_row, e.row);
          check("poly_col", poly_col, e.col);
          check("poly_index", poly_index, e.row * K + e.col);
          if (poly_index < K * K) cap_idx[poly_index] = poly_data;
        end
      end
      if (chk_gap && poly_valid && !pv_prev) check("sample_latency", cyc - t_done, exp_gap);
    end
    pv_prev = poly_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_exhaust, 0);
    check("rst_xof_req", xof_req, 0);
    check("rst_b0", xof_b0, 0);
    check("rst_b1", xof_b1, 0);
    check("rst_valid", poly_valid, 0);
    check_poly("rst_data", poly_data, '0);
    check("rst_row", poly_row, 0);
    check("rst_col", poly_col, 0);
    check("rst_index", poly_index, 0);
`ifdef MATRIX_EXP_STORE_EN
    check("rst_rd_data", rd_data, 0);
`endif
  endtask

  task automatic begin_run(input logic tr);
    order = 0; run_tr = tr; exp_err = 0;
    sb.delete();
    transpose = tr;
    start = 1'b1;
    tick();
    start = 1'b0;
    transpose = 1'b0;
    @(negedge clk);
    check("xof_req_after_start", xof_req, 1);
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err_exhaust, 0);
  endtask

  task automatic wait_done();
    logic seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_after_last_hs", cyc - t_hs, 1);
      check("all_polys", order, K * K);
      check("sb_drained", sb.size(), 0);
      check("err_exhaust", err_exhaust, exp_err);
      check("busy_low_at_done", busy, 0);
    end
    tick();
  endtask

  initial begin
    vec_t vt[4];
    logic seen, stable;
    logic [N*CW-1:0] snap;
    logic [3:0] snap_idx;

    vt[0] = '{bytes: 48'h01D00D_020000, c0: 1,    c1: 221};
    vt[1] = '{bytes: 48'h010DFF_050000, c0: 5,    c1: 0};
    vt[2] = '{bytes: 48'h000DFF_070000, c0: 3328, c1: 7};
    vt[3] = '{bytes: 48'hFFFFFF_0A0000, c0: 10,   c1: 0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset();
    tick();

    for (int i = 0; i < 4; i++) begin
      pfx = vt[i].bytes;
      pfx_en = 1'b1;
      begin_run(1'b0);
      wait_done();
      check("tbl_coef0", cap_idx[0][0 +: CW], vt[i].c0);
      check("tbl_coef1", cap_idx[0][CW +: CW], vt[i].c1);
    end
    pfx_en = 1'b0;

    begin_run(1'b0);
    wait_done();
    exp_n = exp_idx;
    begin_run(1'b1);
    wait_done();
    check_poly("transpose_idx1_eq_idx3", cap_idx[1], exp_n[3]);

    smode = 2; chk_gap = 1; exp_gap = 128 + 2;
    begin_run(1'b0);
    wait_done();
    smode = 1; exp_gap = 224 + 2;
    begin_run(1'b0);
    wait_done();
    check("err_exhaust_all_ff", err_exhaust, 1);
    check_poly("ff_poly8_zero", cap_idx[8], '0);
    smode = 0; chk_gap = 0;

    poly_ready = 1'b0;
    begin_run(1'b0);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (poly_valid) seen = 1;
    end
    check("stall_valid_seen", seen, 1);
    snap = poly_data;
    snap_idx = poly_index;
    check("stall_first_index", snap_idx, 0);
    stable = 1;
    for (int j = 0; j < 50; j++) begin
      start = (j == 10);
      @(negedge clk);
      if (poly_valid !== 1'b1 || poly_data !== snap || poly_index !== snap_idx ||
          poly_row !== 2'd0 || poly_col !== 2'd0) stable = 0;
    end
    start = 1'b0;
    check("stall_stable", stable, 1);
    poly_ready = 1'b1;
    wait_done();
    stable = 1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (busy || xof_req) stable = 0;
    end
    check("start_while_busy_ignored", stable, 1);
    tick();

    begin_run(1'b0);
    seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (order == 5) seen = 1;
    end
    check("reached_poly4", seen, 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset();
    sb.delete();
    tick();
    rst = 1'b0;
    tick();

    begin_run(1'b0);
    wait_done();
`ifdef MATRIX_EXP_STORE_EN
    rd_index = 4'd8;
    rd_coef = 8'd255;
    tick();
    @(negedge clk);
    check("store_rd_8_255", rd_data, exp_idx[8][255*CW +: CW]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/kyber_matrix_expander.md
# kyber_matrix_expander

Parametrised expander for the Kyber public matrix Â (K×K polynomials, N coefficients each). It sits between the SHAKE128 XOF engine and the NTT-domain matrix–vector multiplier. For every (row, col) it requests an XOF stream from the seed with the two index bytes, then rejection-samples the stream into N coefficients in [0, Q−1]. Each finished polynomial is emitted on a valid/ready stream. It extends the fixed K=3 generator with a runtime transpose mode, downstream backpressure and stream-exhaustion detection.

## Interface
- K, 3, matrix dimension (2/3/4 → Kyber512/768/1024)
- N, 256, coefficients per polynomial
- COEF_W, 16, stored coefficient width (zero-extended from 12 bits)
- Q, 3329, modulus / rejection bound
- STREAM_BITS, 5376, XOF output length per polynomial (multiple of 24)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin expansion; sampled only in IDLE
- transpose  in  1  0: generate Â; 1: generate Âᵀ; latched at start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse after the last polynomial handshake
- err_exhaust  out  1  sticky; set if any stream ran out before N coefficients; cleared on start
- xof_req  out  1  one-cycle request pulse to the XOF
- xof_b0, xof_b1  out  8 each  index bytes appended to the seed
- xof_done  in  1  XOF stream valid; held until the next xof_req
- xof_stream  in  STREAM_BITS  byte 0 at bits [7:0]
- poly_valid  out  1  polynomial available
- poly_ready  in  1  consumer accepts
- poly_data  out  N*COEF_W  coefficient c at [c*COEF_W +: COEF_W]
- poly_row, poly_col  out  $clog2(K) each  position in the generated matrix
- poly_index  out  4  row*K + col

## Operation
- States: IDLE → XOF_REQ → XOF_WAIT → SAMPLE → OUT → (XOF_REQ | DONE) → IDLE.
- IDLE: on start, latch transpose, set row=col=0, clear err_exhaust, set busy.
- XOF_REQ: pulse xof_req for one cycle. transpose=0 drives xof_b0=col and xof_b1=row; transpose=1 drives xof_b0=row and xof_b1=col.
- XOF_WAIT: wait for xof_done, then clear the sample counters.
- SAMPLE: consume one 3-byte group per cycle:
  - d1 = b0 + 256·(b1 & 0xF), d2 = (b1>>4) + 16·b2.
  - Accept each value that is < Q, in order d1 then d2.
  - At most 2 writes per cycle. Stop at N; d2 is discarded if d1 fills slot N−1.
  - If all STREAM_BITS/24 groups are consumed with count < N, set err_exhaust and zero-fill the remaining slots. The next state is still OUT.
- OUT: hold poly_valid with stable data and indices until poly_ready. On handshake, advance col (wrap to 0, row+1). After (K−1, K−1), go to DONE.
- DONE: pulse done, drop busy, return to IDLE.
- start while busy is ignored.
- rst mid-operation: all state returns to IDLE and the partial polynomial is discarded.

## Timing
- Reset values: busy=0, done=0, err_exhaust=0, xof_req=0, xof_b0/b1=0, poly_valid=0, poly_data=0, poly_row/col/index=0.
- xof_req is asserted the cycle after start is accepted.
- SAMPLE takes at most STREAM_BITS/24 cycles (224 at the default). With no rejections it takes N/2 = 128 cycles.
- poly_valid rises the cycle after sampling ends.
- The next xof_req follows the poly handshake by one cycle.
- done occurs one cycle after the final handshake.
- Total time ≈ K²·(2 + XOF latency + sample cycles + 1 + ready stall).

## Configuration
- MATRIX_EXP_STORE_EN defined:
  - Adds an internal store A[K*K][N] of COEF_W bits, written on each poly handshake.
  - Adds a read port: rd_index (in, 4), rd_coef (in, $clog2(N)), rd_data (out, COEF_W).
  - Read latency is 1 cycle; rd_data resets to 0.
- Undefined: no store and no read ports; streaming output only.

## Structure
- Package kyber_pkg holds Q, N, COEF_W, the STREAM_BITS default, the state enum and the poly_t packed type.
- Sub-module: poly_rej_sampler. It takes the stream and a start pulse and returns coefficients, a done flag and an exhausted flag. The top FSM owns the XOF handshake, indexing and output.

## Test plan
- K=3, transpose=0, XOF model returning the FIPS-203 stream for seed 0x00…00 → 9 polys in order index 0..8; xof_b0/b1 for index 1 are (1,0); coefficients match the golden model.
- Stream starting with bytes 01 D0 0D → coef[0]=1, coef[1]=221. Bytes 01 0D xx → d1=3329 rejected. Bytes 00 0D xx → d1=3328 accepted.
- Stream of all 0xFF → no coefficients accepted, err_exhaust=1 after 224 sample cycles, poly_data all zero, remaining polys still produced.
- transpose=1 → xof_b0/b1 for index 1 are (0,1); poly_data equals the transpose=0 poly at index 3.
- poly_ready held low for 50 cycles → poly_valid, poly_data and indices stay stable. Start pulsed during busy → ignored.
- rst asserted mid-SAMPLE of poly 4 → all outputs at reset values next cycle. A new start regenerates from index 0. With MATRIX_EXP_STORE_EN, reading (8, 255) after done returns the last coefficient.
